// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU-op encoding, control bundle.
// Used by id_stage; no configuration macros here.
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNC   = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
        alu_op_e alu_op;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = CTRL_NONE;
        case (opcode)
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALU_FUNC;
            end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_FUNC;
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                c.branch = 1'b1;
                c.alu_op = ALU_BRANCH;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Only these formats carry a real rs2 operand; elsewhere bits [24:20] are immediate.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Integer register file, two combinational reads and one write, x0 hardwired to zero.
// REGFILE_WRITE_THROUGH_EN: a same-cycle write to a read index is bypassed to that read.
module id_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [2**REG_AW];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef REGFILE_WRITE_THROUGH_EN
        if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID and ID/EX registers, regfile, immediate/control decode, load-use stall.
// Honours REGFILE_WRITE_THROUGH_EN through the id_regfile instance.
module id_stage
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [31:0]       i_instr,
    input  logic              i_flush,
    input  logic              i_regWrite,
    input  logic [REG_AW-1:0] i_rdAddr,
    input  logic [DATA_W-1:0] i_rdData,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_rs1Data,
    output logic [DATA_W-1:0] o_rs2Data,
    output logic [DATA_W-1:0] o_imm,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2,
    output logic [REG_AW-1:0] o_rd,
    output logic [2:0]        o_funct3,
    output logic              o_funct7b5,
    output logic              o_aluSrc,
    output logic              o_memRead,
    output logic              o_memWrite,
    output logic              o_regWrite,
    output logic              o_memToReg,
    output logic              o_branch,
    output logic [1:0]        o_aluOp,
    output logic              o_illegal
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        ctrl_t             ctrl;
    } idex_t;

    logic [DATA_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    idex_t             idex_q, idex_d;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] dec_rs1, dec_rs2;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic [31:0]       imm32;
    idex_t             decoded;
    logic              hazard;

    assign opcode  = ifid_instr_q[6:0];
    assign dec_rs1 = ifid_instr_q[15 +: REG_AW];
    assign dec_rs2 = ifid_instr_q[20 +: REG_AW];

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk_i    (i_clk),
        .reset_i  (i_reset),
        .we_i     (i_regWrite),
        .waddr_i  (i_rdAddr),
        .wdata_i  (i_rdData),
        .raddr1_i (dec_rs1),
        .raddr2_i (dec_rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_IMM, OP_LOAD: imm32 = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
            OP_STORE:        imm32 = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
            OP_BRANCH:       imm32 = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                                      ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
            default:         imm32 = '0;
        endcase
    end

    // An empty IF/ID slot decodes to an all-zero bubble.
    always_comb begin
        decoded = '0;
        if (ifid_valid_q) begin
            decoded.valid    = 1'b1;
            decoded.pc       = ifid_pc_q;
            decoded.rs1_data = rf_rdata1;
            decoded.rs2_data = rf_rdata2;
            decoded.imm      = DATA_W'($signed(imm32));
            decoded.rs1      = dec_rs1;
            decoded.rs2      = dec_rs2;
            decoded.rd       = ifid_instr_q[7 +: REG_AW];
            decoded.funct3   = ifid_instr_q[14:12];
            decoded.funct7b5 = ifid_instr_q[30];
            decoded.ctrl     = decode_ctrl(opcode);
        end
    end

    assign hazard = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rd != '0) && ifid_valid_q &&
                    ((idex_q.rd == dec_rs1) || (uses_rs2(opcode) && (idex_q.rd == dec_rs2)));

    assign o_stall = hazard && !i_flush && !i_reset;

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        idex_d       = '0;
        if (i_flush) begin
            ifid_valid_d = 1'b0;
        end else if (!hazard) begin
            ifid_pc_d    = i_pc;
            ifid_instr_d = i_instr;
            ifid_valid_d = 1'b1;
            idex_d       = decoded;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            idex_q       <= '0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            idex_q       <= idex_d;
        end
    end

    assign o_valid    = idex_q.valid;
    assign o_pc       = idex_q.pc;
    assign o_rs1Data  = idex_q.rs1_data;
    assign o_rs2Data  = idex_q.rs2_data;
    assign o_imm      = idex_q.imm;
    assign o_rs1      = idex_q.rs1;
    assign o_rs2      = idex_q.rs2;
    assign o_rd       = idex_q.rd;
    assign o_funct3   = idex_q.funct3;
    assign o_funct7b5 = idex_q.funct7b5;
    assign o_aluSrc   = idex_q.ctrl.alu_src;
    assign o_memRead  = idex_q.ctrl.mem_read;
    assign o_memWrite = idex_q.ctrl.mem_write;
    assign o_regWrite = idex_q.ctrl.reg_write;
    assign o_memToReg = idex_q.ctrl.mem_to_reg;
    assign o_branch   = idex_q.ctrl.branch;
    assign o_aluOp    = idex_q.ctrl.alu_op;
    assign o_illegal  = idex_q.ctrl.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage that consumes the PC and instruction produced by the fetch stage and feeds the execute stage. It holds the IF/ID and ID/EX pipeline registers, the 32-entry integer register file, the immediate generator and the main control decoder. It also detects load-use hazards, stalling fetch and inserting a bubble into execute.

## Interface

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register address width (2**REG_AW registers).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_pc  in  DATA_W  PC of the fetched instruction.
- i_instr  in  32  fetched instruction.
- i_flush  in  1  taken branch resolved in EX; squash IF/ID and ID/EX contents.
- i_regWrite  in  1  writeback enable.
- i_rdAddr  in  REG_AW  writeback register.
- i_rdData  in  DATA_W  writeback data.
- o_stall  out  1  load-use hazard; fetch must hold its PC (drives the fetch PC hold).
- o_valid  out  1  ID/EX entry holds a real instruction.
- o_pc  out  DATA_W  PC of the ID/EX entry.
- o_rs1Data, o_rs2Data  out  DATA_W  register operands.
- o_imm  out  DATA_W  sign-extended immediate.
- o_rs1, o_rs2, o_rd  out  REG_AW  register indices.
- o_funct3  out  3; o_funct7b5  out  1  ALU function bits.
- o_aluSrc, o_memRead, o_memWrite, o_regWrite, o_memToReg, o_branch  out  1 each  control.
- o_aluOp  out  2  00 add, 01 branch compare, 10 R/I function decode.
- o_illegal  out  1  unsupported opcode.

## Operation

- IF/ID register: captures i_pc and i_instr and sets ifid_valid=1 each edge unless held by a stall.
- Decode works combinationally on the IF/ID contents. The result is registered into ID/EX on the next edge.
- Opcodes and their control (all unlisted control bits 0):
  - R 0110011: regWrite, aluOp=10.
  - I-ALU 0010011: regWrite, aluSrc, aluOp=10.
  - Load 0000011: regWrite, aluSrc, memRead, memToReg, aluOp=00.
  - Store 0100011: aluSrc, memWrite, aluOp=00.
  - Branch 1100011: branch, aluOp=01.
- Any other opcode: all control bits 0 and o_illegal=1.
- Immediates (sign-extended from instr[31]):
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - R-type: 0.
- Register file:
  - 2 combinational read ports, 1 write port.
  - A write to x0 is discarded; x0 always reads 0.
- Hazard:
  - o_stall = o_valid & o_memRead & (o_rd != 0) & ifid_valid & (o_rd == rs1 or o_rd == rs2 of the IF/ID instruction). rs2 is compared only for R, store and branch.
  - On stall: IF/ID holds its contents; ID/EX loads a bubble (valid=0, all control bits 0).
- Flush: on the next edge ifid_valid=0 and o_valid=0. An invalid IF/ID entry decodes to a bubble.
- Priority: reset > flush > stall. o_stall is forced to 0 while i_flush=1.
- Reset:
  - All outputs 0, including o_valid, o_stall and o_illegal.
  - ifid_valid=0.
  - All registers cleared to 0.

## Timing

- Latency: i_pc/i_instr sampled at edge N appear on outputs after edge N+1.
- o_stall is combinational from ID/EX and IF/ID state in the same cycle and lasts exactly 1 cycle per load-use hazard.
- A writeback at edge N is visible to a read that occurs at or after edge N (see Configuration for the same-cycle case).
- Reset asserted mid-stall or mid-flush: state is cleared on that edge, and no stall is asserted in the following cycle.

## Configuration

- REGFILE_WRITE_THROUGH_EN:
  - Defined: if i_regWrite & i_rdAddr!=0 & i_rdAddr matches a read index in the same cycle, that read returns i_rdData.
  - Undefined: the read returns the old register contents, and the execute stage must forward from writeback.

## Structure

- Shared package id_pkg holds:
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - The aluOp encoding enum.
  - A packed struct ctrl_t carrying the control bits.
- One sub-module: id_regfile (2R/1W, x0 hardwired, optional write-through).

## Test plan

- Reset: hold i_reset for 2 cycles → all outputs 0; o_rs1Data for x5 reads 0.
- Writeback then read: write x5=0x0000_1234, then decode add x7,x5,x6 (0x006283B3) → o_rs1Data=0x1234, o_rd=7, aluOp=10, regWrite=1 two edges after input.
- Immediate: decode beq with offset -8 (0xFE000CE3) → o_imm=0xFFFF_FFF8, branch=1. Decode sw with offset 12 → o_imm=0x0000_000C.
- Load-use: lw x5,0(x1) followed by add x7,x5,x6 → o_stall=1 for exactly 1 cycle, one bubble (o_valid=0), then add issues with correct operands.
- Flush during stall: assert i_flush in the cycle o_stall=1 → o_stall=0; next cycle o_valid=0 and IF/ID is invalidated.
- Same-cycle write/read of x5 and write to x0: with the macro defined, the read returns the new data; without it, the old data; the write to x0 always reads back 0.
